// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 ALU sequencer: ALU opcodes, function codes,
// rotate amounts, FSM states and the micro-op record produced by the micro-op ROM.
package sha256_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_ROTR = 5'd4;
    localparam logic [4:0] OP_SRA  = 5'd5;

    localparam logic [1:0] FUNC_BSIG0 = 2'd0;
    localparam logic [1:0] FUNC_BSIG1 = 2'd1;
    localparam logic [1:0] FUNC_CH    = 2'd2;
    localparam logic [1:0] FUNC_MAJ   = 2'd3;

    localparam logic [4:0] ROT_S0_A = 5'd2;
    localparam logic [4:0] ROT_S0_B = 5'd13;
    localparam logic [4:0] ROT_S0_C = 5'd22;
    localparam logic [4:0] ROT_S1_A = 5'd6;
    localparam logic [4:0] ROT_S1_B = 5'd11;
    localparam logic [4:0] ROT_S1_C = 5'd25;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
    typedef enum logic [2:0] {SRC_X, SRC_Y, SRC_Z, SRC_ACC, SRC_TMP} src_t;
    typedef enum logic {DST_ACC, DST_TMP} dst_t;

    typedef struct packed {
        logic [4:0] opcode;
        src_t       srcA;
        src_t       srcB;
        logic [4:0] shamt;
        dst_t       dest;
        logic       last;
    } uop_t;

    function automatic uop_t mkUop(logic [4:0] op, src_t a, src_t b, logic [4:0] sh,
                                   dst_t d, logic last);
        uop_t u;
        u.opcode = op;
        u.srcA   = a;
        u.srcB   = b;
        u.shamt  = sh;
        u.dest   = d;
        u.last   = last;
        return u;
    endfunction

endpackage

// File: rtl/sha256_uop_rom.sv
// Combinational micro-op table: maps (function, step) to the ALU operation,
// operand sources, rotate amount, destination register and end-of-sequence flag.
module sha256_uop_rom
    import sha256_pkg::*;
(
    input  logic [1:0] i_func,
    input  logic [2:0] i_step,
    output uop_t       o_uop
);

    logic [4:0] w_rotA;
    logic [4:0] w_rotB;
    logic [4:0] w_rotC;

    // BSIG0 and BSIG1 share one sequence shape; only the rotate amounts differ.
    assign w_rotA = (i_func == FUNC_BSIG1) ? ROT_S1_A : ROT_S0_A;
    assign w_rotB = (i_func == FUNC_BSIG1) ? ROT_S1_B : ROT_S0_B;
    assign w_rotC = (i_func == FUNC_BSIG1) ? ROT_S1_C : ROT_S0_C;

    always_comb begin
        o_uop = mkUop(OP_ADD, SRC_X, SRC_X, 5'd0, DST_ACC, 1'b1);
        case (i_func)
            FUNC_BSIG0, FUNC_BSIG1: begin
                case (i_step)
                    3'd0:    o_uop = mkUop(OP_ROTR, SRC_X,   SRC_X,   w_rotA, DST_ACC, 1'b0);
                    3'd1:    o_uop = mkUop(OP_ROTR, SRC_X,   SRC_X,   w_rotB, DST_TMP, 1'b0);
                    3'd2:    o_uop = mkUop(OP_XOR,  SRC_ACC, SRC_TMP, 5'd0,   DST_ACC, 1'b0);
                    3'd3:    o_uop = mkUop(OP_ROTR, SRC_X,   SRC_X,   w_rotC, DST_TMP, 1'b0);
                    3'd4:    o_uop = mkUop(OP_XOR,  SRC_ACC, SRC_TMP, 5'd0,   DST_ACC, 1'b1);
                    default: ;
                endcase
            end
            FUNC_CH: begin
                case (i_step)
                    3'd0:    o_uop = mkUop(OP_XOR, SRC_Y, SRC_Z,   5'd0, DST_TMP, 1'b0);
                    3'd1:    o_uop = mkUop(OP_AND, SRC_X, SRC_TMP, 5'd0, DST_TMP, 1'b0);
                    3'd2:    o_uop = mkUop(OP_XOR, SRC_Z, SRC_TMP, 5'd0, DST_ACC, 1'b1);
                    default: ;
                endcase
            end
            default: begin
                case (i_step)
                    3'd0:    o_uop = mkUop(OP_AND, SRC_X,   SRC_Y,   5'd0, DST_ACC, 1'b0);
                    3'd1:    o_uop = mkUop(OP_XOR, SRC_X,   SRC_Y,   5'd0, DST_TMP, 1'b0);
                    3'd2:    o_uop = mkUop(OP_AND, SRC_Z,   SRC_TMP, 5'd0, DST_TMP, 1'b0);
                    3'd3:    o_uop = mkUop(OP_XOR, SRC_ACC, SRC_TMP, 5'd0, DST_ACC, 1'b1);
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sha256_alu_sequencer.sv
// Sequences one SHA-256 logical function (BSIG0/BSIG1/CH/MAJ) through the shared ALU,
// one micro-op per cycle, between a request handshake and a response handshake.
module sha256_alu_sequencer
    import sha256_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_func,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result
);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_func;
    logic [31:0] r_opx;
    logic [31:0] r_opy;
    logic [31:0] r_opz;
    logic [31:0] r_acc;
    logic [31:0] r_tmp;
    logic [2:0]  r_step;
    logic [31:0] r_rspData;
    uop_t        w_uop;
    logic [31:0] w_srcA;
    logic [31:0] w_srcB;

    sha256_uop_rom u_rom (
        .i_func (r_func),
        .i_step (r_step),
        .o_uop  (w_uop)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    // Handshake flags and ALU drives depend only on registered state.
    always_comb begin
        w_nextState  = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_srcA       = '0;
        w_srcB       = '0;
        alu_opcode   = OP_ADD;
        alu_operandA = '0;
        alu_operandB = '0;
        alu_shiftamt = '0;
        case (w_uop.srcA)
            SRC_X:   w_srcA = r_opx;
            SRC_Y:   w_srcA = r_opy;
            SRC_Z:   w_srcA = r_opz;
            SRC_ACC: w_srcA = r_acc;
            SRC_TMP: w_srcA = r_tmp;
            default: w_srcA = '0;
        endcase
        case (w_uop.srcB)
            SRC_X:   w_srcB = r_opx;
            SRC_Y:   w_srcB = r_opy;
            SRC_Z:   w_srcB = r_opz;
            SRC_ACC: w_srcB = r_acc;
            SRC_TMP: w_srcB = r_tmp;
            default: w_srcB = '0;
        endcase
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_nextState = ST_EXEC;
            end
            ST_EXEC: begin
                alu_opcode   = w_uop.opcode;
                alu_operandA = w_srcA;
                alu_operandB = w_srcB;
                alu_shiftamt = w_uop.shamt;
                if (w_uop.last) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_func    <= '0;
            r_opx     <= '0;
            r_opy     <= '0;
            r_opz     <= '0;
            r_acc     <= '0;
            r_tmp     <= '0;
            r_step    <= '0;
            r_rspData <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_func <= req_func;
                        r_opx  <= req_x;
                        r_opy  <= req_y;
                        r_opz  <= req_z;
                        r_acc  <= '0;
                        r_tmp  <= '0;
                        r_step <= '0;
                    end
                end
                ST_EXEC: begin
                    if (w_uop.dest == DST_ACC) r_acc <= alu_result;
                    else                       r_tmp <= alu_result;
                    r_step <= r_step + 3'd1;
                    if (w_uop.last) r_rspData <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = r_rspData;

endmodule

// File: doc/sha256_alu_sequencer.md
# sha256_alu_sequencer

Multi-cycle initiator that drives the shared 32-bit ALU's opcode and operand interface to evaluate the SHA-256 logical functions Σ0, Σ1, Ch and Maj as short micro-op sequences. It sits between the round controller and the ALU. It takes one function request over a valid/ready handshake, issues one ALU operation per cycle, accumulates intermediates in local registers, and returns the 32-bit result over a second valid/ready handshake.

## Interface
Parameters: none; all widths are fixed at 32-bit data, 5-bit opcode and 5-bit shift amount.
- clock  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous assert, active-low; returns the block to IDLE
- req_valid  in  1  request present
- req_ready  out  1  high exactly when the FSM is in IDLE
- req_func  in  2  function: 0=BSIG0, 1=BSIG1, 2=CH, 3=MAJ
- req_x, req_y, req_z  in  32 each  operands; BSIG uses x only; CH uses e=x, f=y, g=z; MAJ uses a=x, b=y, c=z
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  32  result
- alu_operandA, alu_operandB  out  32 each  operands to the ALU
- alu_opcode  out  5  ALU opcode: ADD=0, SUB=1, AND=2, XOR=3, ROTR=4, SRA=5
- alu_shiftamt  out  5  rotate amount to the ALU
- alu_result  in  32  combinational ALU result, sampled in the same cycle

## Operation
- FSM states: IDLE, EXEC, DONE. Registers: opx, opy, opz, acc, tmp, step[2:0], func.
- **IDLE:** req_ready=1. When req_valid=1, latch func and operands into opx/opy/opz, set step=0, clear acc and tmp, and go to EXEC.
- **EXEC:** each cycle drives one micro-op and writes alu_result into acc or tmp. On the last micro-op, go to DONE and load rsp_data with the final value.
- Micro-op sequences:
  - BSIG0: acc=ROTR(x,2); tmp=ROTR(x,13); acc=acc^tmp; tmp=ROTR(x,22); acc=acc^tmp. 5 ops.
  - BSIG1: same sequence with rotate amounts 6, 11, 25. 5 ops.
  - CH: tmp=y^z; tmp=x&tmp; acc=z^tmp. 3 ops.
  - MAJ: acc=x&y; tmp=x^y; tmp=z&tmp; acc=acc^tmp. 4 ops.
- **DONE:** rsp_valid=1 and rsp_data is held stable. On rsp_valid&rsp_ready, go to IDLE. A request cannot be accepted in the same cycle as this handshake.
- Whenever the FSM is not in EXEC, the ALU outputs are driven to opcode=0 (ADD), both operands 0 and shiftamt 0.
- Unused ALU codes: SUB and SRA are never issued. The ALU status flags are not connected.
- Reset values: state=IDLE, so req_ready=1 during and after reset. rsp_valid=0, rsp_data=0, acc=tmp=0, step=0, and all ALU outputs at the idle values above.
- Reset asserted mid-operation: the current operation is aborted with no response and no partial rsp_valid. The block is back in IDLE immediately.
- Operand changes after acceptance have no effect on the result.
- rsp_ready held high while in IDLE or EXEC has no effect.

## Timing
- Request accepted at edge T, that is, in the cycle with req_valid&req_ready.
- EXEC occupies N cycles: BSIG0/BSIG1 N=5, CH N=3, MAJ N=4.
- rsp_valid is high from cycle T+N+1 until the response handshake edge D.
- req_ready is high again from cycle D+1. The minimum request-to-request period is N+2 cycles.
- No combinational path from req_valid or rsp_ready to any output. req_ready and the ALU drives are decoded from registered state only.

## Structure
- Package sha256_pkg holds the ALU opcode constants (ADD, SUB, AND, XOR, ROTR, SRA), the func encodings, the six rotate constants and the state enum.
- One sub-module, sha256_uop_rom: combinational lookup from (func, step) to {opcode, srcA sel (x, y, z, acc, tmp), srcB sel, shamt, dest (acc/tmp), last}.
- The sequencer holds only the FSM, registers and operand muxes.

## Test plan
- BSIG0 x=0x6a09e667 → rsp_data=0xce20b47e; rsp_valid rises exactly 6 cycles after the accept edge. alu_opcode sequence 4,4,3,4,3 with shiftamt 2,13,–,22,–.
- BSIG1 x=0x510e527f → 0x3587272b. CH x=0x510e527f, y=0x9b05688c, z=0x1f83d9ab → 0x1f85c98c with 3 EXEC cycles.
- MAJ x=0x6a09e667, y=0xbb67ae85, z=0x3c6ef372 → 0x3a6fe667. Edge cases: BSIG0(0xffffffff)=0xffffffff, BSIG0(0)=0, CH(0xffffffff,f,g)=f.
- Backpressure: hold rsp_ready=0 for 10 cycles. rsp_valid and rsp_data stay stable, req_ready stays 0, and a new req_valid is ignored until the cycle after the handshake.
- Reset mid-op: assert reset_n=0 during EXEC step 2 of BSIG1. Outputs go immediately to reset values and no response is emitted. A MAJ request issued after release returns the correct value.
- Operand hold: change req_x/req_y/req_z and req_func on every cycle after acceptance. The result still matches the latched operands.
